video_addrgen_scroll: RTL and testbench
=======================================

Name: video_addrgen_scroll

Overview:
- Parametrised successor to the fixed-mode video fetch address generator.
- Produces DRAM word addresses for the video fetcher from a programmable frame description: per-plane base, line stride, visible words per line and wrap height.
- Supports hardware X/Y scrolling with wrap-around and N interleaved bit-planes.
- Sits between the video sync generator (line_start/int_start/vpix) and the DRAM arbiter (video_addr/video_next).

Parameters:
- AW, 21, DRAM word address width.
- PLANES, 2, interleaved planes fetched per X word position (1..4).
- XW, 8, width of X word counter, stride and words-per-line fields.
- YW, 9, width of Y line counter and height field.

Ports:
- clk  in  1  28 MHz system clock
- rst  in  1  asynchronous active-high reset
- line_start  in  1  one-cycle strobe at start of each line
- int_start  in  1  one-cycle strobe at frame start
- vpix  in  1  vertical visible-area window
- video_next  in  1  arbiter consumed current video_addr
- cfg_base  in  PLANES*AW  per-plane base address, plane 0 in LSBs
- cfg_stride  in  XW  words per stored line
- cfg_wpl  in  XW  visible words per line per plane
- cfg_height  in  YW  stored lines before Y wrap
- cfg_xoff  in  XW  horizontal scroll, in words
- cfg_yoff  in  YW  vertical scroll, in lines
- video_addr  out  AW  current fetch address
- fetch_busy  out  1  line fetch sequence in progress
- overrun  out  1  sticky: video_next seen while not busy
- typos  out  3  Y position inside 8-line character row

Behaviour:
- Reset: video_addr=0, fetch_busy=0, overrun=0, typos=0, all counters/accumulators/shadow registers 0.
- Config shadowing:
  - All cfg_* inputs are sampled only on int_start into shadow registers.
  - Mid-frame cfg changes have no effect until the next frame.
- Frame init, on int_start:
  - y = cfg_yoff mod cfg_height.
  - row_acc = y*stride, computed iteratively in the frame-init path: add stride over y cycles before the first line_init. Blanking guarantees the time; no multiplier.
  - fetch_busy=0.
- Line init, on line_start registered one cycle AND vpix:
  - x = xoff, plane p=0, word count wc=0, fetch_busy=1.
  - video_addr = base[0] + row_acc + x, modulo 2^AW; valid the cycle after line init.
- Step, on video_next while fetch_busy:
  - If p<PLANES-1: p=p+1.
  - Otherwise p=0 and x=x+1, wrapping to 0 when x==stride-1. Then wc=wc+1.
  - video_addr updates the next cycle to base[p]+row_acc+x.
  - After wc reaches wpl with p=0: fetch_busy=0 and video_addr holds its last value.
- Line end (on line init of the following line, before reloading x):
  - y=y+1 and row_acc=row_acc+stride.
  - When y==height-1: y=0 and row_acc=0 (vertical wrap).
  - The first visible line uses the frame-init y with no advance.
- typos = y[2:0], registered.
- Simultaneous events:
  - int_start and line init in the same cycle: frame init applies first; the line uses the new shadows.
  - video_next coincident with line init: line init wins and the step is dropped.
  - video_next while !fetch_busy: ignored, overrun=1 (sticky until rst).
- Degenerate config:
  - stride=0 is treated as 1.
  - height=0 is treated as 1.
  - wpl=0: fetch_busy never asserts.
- Reset mid-line: all state clears immediately; no address is issued until the next int_start plus line init.
- All arithmetic is unsigned, truncated to AW.

Decomposition:
- Package video_addrgen_pkg:
  - default widths.
  - plane-select helper to slice cfg_base.
  - function sat1 (zero-to-one clamp).
- Sub-module wrap_counter:
  - parametrised width.
  - load/inc/wrap-limit inputs, wrap output.
  - used for both x and y.

Test Plan:
- PLANES=2, base0=0x8000, base1=0xA000, stride=40, wpl=40, xoff=0, yoff=0; one line -> addresses 0x8000,0xA000,0x8001,0xA001 … 0x8027,0xA027, then fetch_busy=0.
- xoff=38, stride=40, wpl=4, PLANES=1, base=0 -> x words 38,39,0,1 (horizontal wrap).
- height=200, yoff=199, stride=40, PLANES=1, base=0 -> line 0 row base 7960, line 1 row base 0; typos sequence 7,0.
- Change cfg_base mid-frame -> addresses unchanged until after the next int_start.
- video_next asserted after a line completes -> overrun=1 and video_addr unchanged.
- Assert rst mid-line -> all outputs 0 immediately; the next line produces no addresses until int_start.

Source files
------------

// File: rtl/video_addrgen_pkg.sv
// Shared widths and helpers for the scrolling video fetch address generator.
package video_addrgen_pkg;

  localparam int AW_DEF     = 21;
  localparam int PLANES_DEF = 2;
  localparam int XW_DEF     = 8;
  localparam int YW_DEF     = 9;

  // Returns plane p's base from a packed base vector (plane 0 in LSBs); caller truncates to AW.
  function automatic logic [31:0] plane_sel(input logic [127:0] bases, input logic [1:0] p,
                                            input int unsigned aw);
    logic [127:0] sh;
    sh = bases >> (32'(p) * aw);
    return sh[31:0];
  endfunction

  function automatic logic [15:0] sat1(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/video_addrgen_scroll_wrap_counter.sv
// Loadable up-counter that returns to zero after reaching a programmable limit.
module wrap_counter
  import video_addrgen_pkg::*;
#(
  parameter int W = XW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == lim_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (inc_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/video_addrgen_scroll.sv
// Video fetch address generator: per-plane bases, line stride, X/Y scroll with wrap,
// config shadowed at frame start.
module video_addrgen_scroll
  import video_addrgen_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int PLANES = PLANES_DEF,
  parameter int XW     = XW_DEF,
  parameter int YW     = YW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_start,
  input  logic                 int_start,
  input  logic                 vpix,
  input  logic                 video_next,
  input  logic [PLANES*AW-1:0] cfg_base,
  input  logic [XW-1:0]        cfg_stride,
  input  logic [XW-1:0]        cfg_wpl,
  input  logic [YW-1:0]        cfg_height,
  input  logic [XW-1:0]        cfg_xoff,
  input  logic [YW-1:0]        cfg_yoff,
  output logic [AW-1:0]        video_addr,
  output logic                 fetch_busy,
  output logic                 overrun,
  output logic [2:0]           typos
);

  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic [PLANES*AW-1:0] base_q, base_e;
  logic [XW-1:0]        stride_q, wpl_q, xoff_q, wpl_e, xoff_e;
  logic [YW-1:0]        height_q, yoff_q;
  logic [YW-1:0]        ic_q, ic_d;
  logic [AW-1:0]        row_q, row_d, addr_q, addr_d, stride_e;
  logic [PW-1:0]        p_q, p_d;
  logic [XW-1:0]        wc_q, wc_d, wc_inc, x_q, x_nxt, x_lim;
  logic [YW-1:0]        y_q, y_nxt, y_lim;
  logic                 busy_q, busy_d, ovr_q, first_q, first_d, fok_q, ls_q;
  logic                 line_init, step, adv, iter, y_inc, x_inc, p_last, done, y_wrap;
  logic                 unused_x_wrap, unused_y;

  // Same-cycle int_start makes the new config visible to a coincident line init.
  assign base_e = int_start ? cfg_base : base_q;
  assign wpl_e  = int_start ? cfg_wpl  : wpl_q;
  assign xoff_e = int_start ? cfg_xoff : xoff_q;

  assign stride_e = AW'(sat1(16'(stride_q)));
  assign x_lim    = XW'(sat1(16'(stride_q)) - 16'd1);
  assign y_lim    = YW'(sat1(16'(height_q)) - 16'd1);

  assign line_init = ls_q & vpix & (fok_q | int_start);
  assign step      = video_next & busy_q & ~line_init & ~int_start;
  assign adv       = line_init & ~first_q & ~int_start;
  // y*stride is built by stepping y from 0 yoff times, so y also lands on yoff mod height.
  assign iter      = (ic_q != '0) & ~int_start;
  assign y_inc     = iter | adv;
  assign p_last    = (p_q == PW'(PLANES - 1));
  assign x_inc     = step & p_last;
  assign wc_inc    = wc_q + 1'b1;
  assign done      = x_inc & (wc_inc == wpl_q);

  wrap_counter #(.W(XW)) u_x (
    .clk(clk), .rst(rst), .load_i(line_init), .load_val_i(xoff_e), .inc_i(x_inc),
    .lim_i(x_lim), .cnt_o(x_q), .nxt_o(x_nxt), .wrap_o(unused_x_wrap)
  );

  wrap_counter #(.W(YW)) u_y (
    .clk(clk), .rst(rst), .load_i(int_start), .load_val_i('0), .inc_i(y_inc),
    .lim_i(y_lim), .cnt_o(y_q), .nxt_o(y_nxt), .wrap_o(y_wrap)
  );

  assign unused_y = ^{y_q[YW-1:3], y_nxt};

  always_comb begin
    ic_d = ic_q;
    if (int_start) ic_d = cfg_yoff;
    else if (iter) ic_d = ic_q - 1'b1;

    row_d = row_q;
    if (int_start)  row_d = '0;
    else if (y_inc) row_d = y_wrap ? '0 : row_q + stride_e;

    first_d = first_q;
    if (line_init)      first_d = 1'b0;
    else if (int_start) first_d = 1'b1;
  end

  always_comb begin
    p_d    = p_q;
    wc_d   = wc_q;
    busy_d = busy_q;
    addr_d = addr_q;
    if (line_init) begin
      p_d    = '0;
      wc_d   = '0;
      busy_d = (wpl_e != '0);
      addr_d = base_e[AW-1:0] + row_d + AW'(xoff_e);
    end else if (int_start) begin
      busy_d = 1'b0;
    end else if (step) begin
      p_d = p_last ? '0 : p_q + 1'b1;
      if (x_inc) wc_d = wc_inc;
      // The final step ends the line; the last address stays on the bus.
      if (done) busy_d = 1'b0;
      else      addr_d = AW'(plane_sel(128'(base_q), 2'(p_d), AW)) + row_q + AW'(x_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      stride_q <= '0;
      wpl_q    <= '0;
      height_q <= '0;
      xoff_q   <= '0;
      yoff_q   <= '0;
      ic_q     <= '0;
      row_q    <= '0;
      p_q      <= '0;
      wc_q     <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      ovr_q    <= 1'b0;
      first_q  <= 1'b0;
      fok_q    <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      if (int_start) begin
        base_q   <= cfg_base;
        stride_q <= cfg_stride;
        wpl_q    <= cfg_wpl;
        height_q <= cfg_height;
        xoff_q   <= cfg_xoff;
        yoff_q   <= cfg_yoff;
        fok_q    <= 1'b1;
      end
      ic_q    <= ic_d;
      row_q   <= row_d;
      p_q     <= p_d;
      wc_q    <= wc_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      ovr_q   <= ovr_q | (video_next & ~busy_q);
      first_q <= first_d;
      ls_q    <= line_start;
    end
  end

  assign video_addr = addr_q;
  assign fetch_busy = busy_q;
  assign overrun    = ovr_q;
  assign typos      = y_q[2:0];

endmodule

// File: tb/tb_video_addrgen_scroll.sv
// Directed bench: a 2-plane and a 1-plane instance share stimulus; each test checks one of them.
module tb_video_addrgen_scroll;
  localparam int AW = 21, XW = 8, YW = 9;

  logic clk = 1'b0, rst = 1'b1;
  logic line_start = 1'b0, int_start = 1'b0, vpix = 1'b0, video_next = 1'b0;
  logic [2*AW-1:0] cfg_base = '0;
  logic [XW-1:0] cfg_stride = '0, cfg_wpl = '0, cfg_xoff = '0;
  logic [YW-1:0] cfg_height = '0, cfg_yoff = '0;
  logic [AW-1:0] addr2, addr1;
  logic busy2, busy1, ovr2, ovr1;
  logic [2:0] typ2, typ1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  video_addrgen_scroll #(.AW(AW), .PLANES(2), .XW(XW), .YW(YW)) u2 (
    .clk(clk), .rst(rst), .line_start(line_start), .int_start(int_start), .vpix(vpix),
    .video_next(video_next), .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_wpl(cfg_wpl),
    .cfg_height(cfg_height), .cfg_xoff(cfg_xoff), .cfg_yoff(cfg_yoff),
    .video_addr(addr2), .fetch_busy(busy2), .overrun(ovr2), .typos(typ2)
  );

  video_addrgen_scroll #(.AW(AW), .PLANES(1), .XW(XW), .YW(YW)) u1 (
    .clk(clk), .rst(rst), .line_start(line_start), .int_start(int_start), .vpix(vpix),
    .video_next(video_next), .cfg_base(cfg_base[AW-1:0]), .cfg_stride(cfg_stride),
    .cfg_wpl(cfg_wpl), .cfg_height(cfg_height), .cfg_xoff(cfg_xoff), .cfg_yoff(cfg_yoff),
    .video_addr(addr1), .fetch_busy(busy1), .overrun(ovr1), .typos(typ1)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                         input logic [XW-1:0] st, input logic [XW-1:0] wpl,
                         input logic [XW-1:0] xo, input logic [YW-1:0] h,
                         input logic [YW-1:0] yo);
    cfg_base = {b1, b0}; cfg_stride = st; cfg_wpl = wpl; cfg_xoff = xo;
    cfg_height = h; cfg_yoff = yo;
  endtask

  task automatic frame();
    int_start = 1'b1; tick(); int_start = 1'b0;
    repeat (220) tick();
  endtask

  task automatic line();
    vpix = 1'b1; line_start = 1'b1; tick(); line_start = 1'b0; tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if ({addr2, busy2, ovr2, typ2} !== '0) begin bad++;
      $display("FAIL reset2: got %0h/%0b/%0b/%0d want 0", addr2, busy2, ovr2, typ2); end
    total++; if ({addr1, busy1, ovr1, typ1} !== '0) begin bad++;
      $display("FAIL reset1: got %0h/%0b/%0b/%0d want 0", addr1, busy1, ovr1, typ1); end
    tick(); tick(); rst = 1'b0; tick();
  endtask

  task automatic test_two_plane_line();
    logic [AW-1:0] exp;
    set_cfg(21'h8000, 21'hA000, 8'd40, 8'd40, 8'd0, 9'd200, 9'd0);
    frame(); line();
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL tp_busy: got %b want 1", busy2); end
    for (int k = 0; k < 80; k++) begin
      exp = ((k % 2) ? 21'hA000 : 21'h8000) + AW'(k / 2);
      total++; if (addr2 !== exp) begin bad++;
        $display("FAIL tp_addr[%0d]: got %0h want %0h", k, addr2, exp); end
      video_next = 1'b1; tick();
    end
    video_next = 1'b0;
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL tp_end_busy: got %b want 0", busy2); end
    total++; if (addr2 !== 21'hA027) begin bad++;
      $display("FAIL tp_hold: got %0h want a027", addr2); end
    total++; if (ovr2 !== 1'b0) begin bad++; $display("FAIL tp_ovr: got %b want 0", ovr2); end
  endtask

  task automatic test_xwrap();
    logic [AW-1:0] exp;
    set_cfg(21'h0, 21'h0, 8'd40, 8'd4, 8'd38, 9'd200, 9'd0);
    frame(); line();
    for (int k = 0; k < 4; k++) begin
      exp = AW'((38 + k) % 40);
      total++; if (addr1 !== exp) begin bad++;
        $display("FAIL xwrap[%0d]: got %0d want %0d", k, addr1, exp); end
      video_next = 1'b1; tick();
    end
    video_next = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL xwrap_busy: got %b want 0", busy1); end
    total++; if (addr1 !== 21'd1) begin bad++; $display("FAIL xwrap_hold: got %0d want 1", addr1); end
  endtask

  task automatic test_ywrap();
    set_cfg(21'h0, 21'h0, 8'd40, 8'd4, 8'd0, 9'd200, 9'd199);
    frame(); line();
    total++; if (addr1 !== 21'd7960) begin bad++; $display("FAIL ywrap_l0: got %0d want 7960", addr1); end
    total++; if (typ1 !== 3'd7) begin bad++; $display("FAIL ywrap_t0: got %0d want 7", typ1); end
    repeat (5) tick();
    line();
    total++; if (addr1 !== 21'd0) begin bad++; $display("FAIL ywrap_l1: got %0d want 0", addr1); end
    total++; if (typ1 !== 3'd0) begin bad++; $display("FAIL ywrap_t1: got %0d want 0", typ1); end
  endtask

  task automatic test_cfg_shadow();
    set_cfg(21'h8000, 21'hA000, 8'd40, 8'd40, 8'd0, 9'd200, 9'd0);
    frame(); line();
    total++; if (addr2 !== 21'h8000) begin bad++; $display("FAIL shd_l0: got %0h want 8000", addr2); end
    cfg_base = {21'h1000, 21'h2000};
    tick(); line();
    total++; if (addr2 !== 21'h8028) begin bad++; $display("FAIL shd_l1: got %0h want 8028", addr2); end
    frame(); line();
    total++; if (addr2 !== 21'h2000) begin bad++; $display("FAIL shd_new: got %0h want 2000", addr2); end
  endtask

  task automatic test_overrun();
    logic [AW-1:0] exp;
    set_cfg(21'h2000, 21'h1000, 8'd40, 8'd2, 8'd0, 9'd200, 9'd0);
    frame();
    total++; if (ovr2 !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %b want 0", ovr2); end
    line();
    for (int k = 0; k < 4; k++) begin
      exp = ((k % 2) ? 21'h1000 : 21'h2000) + AW'(k / 2);
      total++; if (addr2 !== exp) begin bad++;
        $display("FAIL ovr_addr[%0d]: got %0h want %0h", k, addr2, exp); end
      video_next = 1'b1; tick();
    end
    video_next = 1'b0;
    total++; if ({busy2, ovr2} !== 2'b00) begin bad++;
      $display("FAIL ovr_done: got busy=%b ovr=%b want 0 0", busy2, ovr2); end
    video_next = 1'b1; tick(); video_next = 1'b0; tick();
    total++; if (ovr2 !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ovr2); end
    total++; if (addr2 !== 21'h1001) begin bad++; $display("FAIL ovr_addr: got %0h want 1001", addr2); end
    repeat (3) tick();
    total++; if (ovr2 !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr2); end
  endtask

  task automatic test_degenerate();
    set_cfg(21'h100, 21'h100, 8'd0, 8'd2, 8'd0, 9'd0, 9'd5);
    frame(); line();
    total++; if (addr1 !== 21'h100) begin bad++; $display("FAIL dg_l0: got %0h want 100", addr1); end
    total++; if (typ1 !== 3'd0) begin bad++; $display("FAIL dg_typ: got %0d want 0", typ1); end
    video_next = 1'b1; tick(); video_next = 1'b0;
    total++; if ({addr1, busy1} !== {21'h100, 1'b1}) begin bad++;
      $display("FAIL dg_step: got %0h/%b want 100/1", addr1, busy1); end
    line();
    total++; if (addr1 !== 21'h100) begin bad++; $display("FAIL dg_l1: got %0h want 100", addr1); end
    cfg_wpl = 8'd0;
    frame(); line();
    total++; if ({busy1, busy2} !== 2'b00) begin bad++;
      $display("FAIL dg_wpl0: got %b%b want 00", busy1, busy2); end
  endtask

  task automatic test_rst_midline();
    set_cfg(21'h2000, 21'h1000, 8'd40, 8'd2, 8'd0, 9'd200, 9'd3);
    frame(); line();
    total++; if ({addr2, typ2} !== {21'h2078, 3'd3}) begin bad++;
      $display("FAIL rm_l0: got %0h/%0d want 2078/3", addr2, typ2); end
    video_next = 1'b1; tick(); video_next = 1'b0;
    total++; if (addr2 !== 21'h1078) begin bad++; $display("FAIL rm_step: got %0h want 1078", addr2); end
    rst = 1'b1; #1;
    total++; if ({addr2, busy2, ovr2, typ2} !== '0) begin bad++;
      $display("FAIL rm_clear: got %0h/%b/%b/%0d want 0", addr2, busy2, ovr2, typ2); end
    tick(); rst = 1'b0; tick();
    line();
    total++; if ({addr2, busy2} !== '0) begin bad++;
      $display("FAIL rm_noframe: got %0h/%b want 0/0", addr2, busy2); end
    frame(); line();
    total++; if ({addr2, typ2, busy2} !== {21'h2078, 3'd3, 1'b1}) begin bad++;
      $display("FAIL rm_resume: got %0h/%0d/%b want 2078/3/1", addr2, typ2, busy2); end
  endtask

  initial begin
    test_reset();
    test_two_plane_line();
    test_xwrap();
    test_ywrap();
    test_cfg_shadow();
    test_overrun();
    test_degenerate();
    test_rst_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
